// File: rtl/branch_resolve_pkg.sv
// Shared constants and types for the branch resolution unit.
// Queue entries are packed as {taken, pc, target}, with the taken bit as the MSB.
package branch_resolve_pkg;

    localparam logic        RESET_LVL  = 1'b0;
    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        ResNone,
        ResHit,
        ResMiss,
        ResErr
    } res_kind_e;

    function automatic int unsigned entry_width(input int unsigned addr_w);
        return 1 + 2 * addr_w;
    endfunction

endpackage

// File: rtl/branch_resolve_bq_fifo.sv
// In-order queue of in-flight branches.
// Occupancy is tracked by count, so full and empty never rely on pointer equality.
module bq_fifo
    import branch_resolve_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // clear wins over push/pop: a clearing cycle leaves the queue empty.
    always_ff @(posedge clk) begin
        if (rst == RESET_LVL || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves queued branch predictions against execute outcomes.
// Trains the predictor, flushes and redirects on mispredict, and counts branches and misses.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_pc,
    input  logic [ADDR_W-1:0] pred_target,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              upd_valid,
    output logic              upd_taken,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              res_err,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned EW = entry_width(ADDR_W);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [EW-1:0]     head, wdata;
    logic [CW-1:0]     count;
    logic              head_taken;
    logic [ADDR_W-1:0] head_pc, head_target, fix_pc;
    logic              push, pop, clear;
    res_kind_e         kind;

    logic              upd_valid_q, upd_taken_q, flush_q, res_err_q;
    logic [ADDR_W-1:0] redirect_q;
    logic [CNT_W-1:0]  br_cnt_q, miss_cnt_q;

    assign head_taken  = head[2*ADDR_W];
    assign head_pc     = head[2*ADDR_W-1 -: ADDR_W];
    assign head_target = head[ADDR_W-1:0];
    assign wdata       = {pred_taken, pred_pc, pred_target};

    // Ready is based on registered occupancy only; a same-cycle pop does not free a slot.
    assign pred_ready = (count != CW'(DEPTH));

    always_comb begin
        kind = ResNone;
        if (res_valid) begin
            if (count == '0) begin
                kind = ResErr;
            end else if (head_taken != res_taken) begin
                kind = ResMiss;
            end else begin
                kind = ResHit;
            end
        end
    end

    // Any push alongside a mispredict is on the wrong path and is discarded.
    assign pop    = (kind == ResHit) || (kind == ResMiss);
    assign clear  = (kind == ResMiss);
    assign push   = pred_valid && pred_ready && !clear;
    assign fix_pc = res_taken ? head_target : head_pc + ADDR_W'(INSN_BYTES);

    bq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_bq_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst == RESET_LVL) begin
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            flush_q     <= 1'b0;
            res_err_q   <= 1'b0;
            redirect_q  <= '0;
            br_cnt_q    <= '0;
            miss_cnt_q  <= '0;
        end else begin
            upd_valid_q <= pop;
            upd_taken_q <= pop && res_taken;
            flush_q     <= clear;
            res_err_q   <= (kind == ResErr);
            if (clear) begin
                redirect_q <= fix_pc;
            end
            if (pop && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + 1'b1;
            end
            if (clear && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign upd_valid   = upd_valid_q;
    assign upd_taken   = upd_taken_q;
    assign flush       = flush_q;
    assign res_err     = res_err_q;
    assign redirect_pc = redirect_q;
    assign br_cnt      = br_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Randomised scoreboard bench for branch_resolve against a queue-based reference model.
// CNT_W is reduced so counter saturation is reachable in a short run.
module tb_branch_resolve;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 12;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk, rst;
    logic              pred_valid, pred_taken, pred_ready;
    logic [ADDR_W-1:0] pred_pc, pred_target, redirect_pc;
    logic              res_valid, res_taken;
    logic              upd_valid, upd_taken, flush, res_err;
    logic [CNT_W-1:0]  br_cnt, miss_cnt;

    branch_resolve #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_pc     (pred_pc),
        .pred_target (pred_target),
        .pred_ready  (pred_ready),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .upd_valid   (upd_valid),
        .upd_taken   (upd_taken),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .res_err     (res_err),
        .br_cnt      (br_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          taken;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        bit          upd;
        bit          taken;
        bit          flush;
        bit          err;
        logic [31:0] redir;
        int          br;
        int          miss;
        int          due;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   m_br, m_miss;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: whenever the DUT presents a response, pop and compare the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                if (upd_valid || flush || res_err) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_output: got upd=%b flush=%b err=%b expected none",
                                 upd_valid, flush, res_err);
                    end else begin
                        e = sb.pop_front();
                        chk("upd_valid", 32'(upd_valid), 32'(e.upd));
                        chk("upd_taken", 32'(upd_taken), 32'(e.taken));
                        chk("flush", 32'(flush), 32'(e.flush));
                        chk("res_err", 32'(res_err), 32'(e.err));
                        chk("br_cnt", 32'(br_cnt), 32'(e.br));
                        chk("miss_cnt", 32'(miss_cnt), 32'(e.miss));
                        if (e.flush) chk("redirect_pc", redirect_pc, e.redir);
                    end
                end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_output: got none expected upd=%b flush=%b err=%b",
                             e.upd, e.flush, e.err);
                end
            end
        end
    end

    // One cycle of stimulus, applied at negedge; the model predicts the next-cycle response.
    task automatic step(input bit pv, input bit pt, input logic [31:0] ppc,
                        input logic [31:0] ptg, input bit rv, input bit rt);
        bit   ready, pushing;
        ent_t h;
        exp_t e;
        ready = (mq.size() != DEPTH);
        chk("pred_ready", 32'(pred_ready), 32'(ready));
        pred_valid  = pv;
        pred_taken  = pt;
        pred_pc     = ppc;
        pred_target = ptg;
        res_valid   = rv;
        res_taken   = rt;
        pushing     = pv && ready;
        if (rv) begin
            e.upd = 0; e.taken = 0; e.flush = 0; e.err = 0; e.redir = '0;
            if (mq.size() == 0) begin
                e.err = 1;
            end else begin
                h       = mq.pop_front();
                e.upd   = 1;
                e.taken = rt;
                m_br    = (m_br < CMAX) ? m_br + 1 : CMAX;
                if (h.taken != rt) begin
                    e.flush = 1;
                    m_miss  = (m_miss < CMAX) ? m_miss + 1 : CMAX;
                    e.redir = rt ? h.tgt : h.pc + 32'd4;
                    mq.delete();
                    pushing = 0;
                end
            end
            e.br   = m_br;
            e.miss = m_miss;
            e.due  = cyc + 1;
            sb.push_back(e);
        end
        if (pushing) begin
            h.taken = pt;
            h.pc    = ppc;
            h.tgt   = ptg;
            mq.push_back(h);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        mq.delete();
        sb.delete();
        m_br   = 0;
        m_miss = 0;
        repeat (2) @(negedge clk);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_upd_taken", 32'(upd_taken), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_br_cnt", 32'(br_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("rst_pred_ready", 32'(pred_ready), 32'd1);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit rt;
        pred_taken  = 1'b0;
        pred_pc     = '0;
        pred_target = '0;
        res_taken   = 1'b0;
        @(negedge clk);
        do_reset();

        // Correct taken prediction, then both mispredict directions.
        step(1, 1, 32'h100, 32'h200, 0, 0);
        step(0, 0, 32'h0, 32'h0, 1, 1);
        step(1, 0, 32'h100, 32'h200, 0, 0);
        step(0, 0, 32'h0, 32'h0, 1, 1);
        step(1, 1, 32'h100, 32'h200, 0, 0);
        step(0, 0, 32'h0, 32'h0, 1, 0);

        // Fill to DEPTH, the fifth push is dropped; drain in order with alternating outcomes.
        for (int i = 0; i < 5; i++) step(1, i[0], 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 32'h0, 1, i[0]);
        step(0, 0, 32'h0, 32'h0, 1, 0);

        // Mispredict with a same-cycle push clears everything; next resolve is an error.
        for (int i = 0; i < 3; i++) step(1, 1, 32'h3000 + 32'(i * 4), 32'h4000, 0, 0);
        step(1, 1, 32'h3100, 32'h4100, 1, 0);
        step(0, 0, 32'h0, 32'h0, 1, 0);

        // PC + 4 wraps to zero.
        step(1, 1, 32'hFFFF_FFFC, 32'h40, 0, 0);
        step(0, 0, 32'h0, 32'h0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (mq.size() > 0 && ($urandom % 4) != 0) rt = mq[0].taken;
            else rt = 1'($urandom);
            step(($urandom % 5) < 3, 1'($urandom), $urandom, $urandom, ($urandom % 2) == 0, rt);
        end

        // Drive enough mispredicts to saturate both counters.
        do_reset();
        for (int k = 0; k < CMAX + 5; k++) begin
            step(1, 1, 32'(k * 4), 32'h8000, 0, 0);
            step(0, 0, 32'h0, 32'h0, 1, 0);
        end
        step(0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 32'h0, 0, 0);
        chk("miss_cnt_saturated", 32'(miss_cnt), 32'(CMAX));
        chk("br_cnt_saturated", 32'(br_cnt), 32'(CMAX));
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
